// File: rtl/dsp48_dot_seq_if.sv
// Term/result stream bundle for dsp48_dot_seq.
//   slave  : the sequencer (consumes terms, produces results)
//   master : the stream source/sink driving it
// Signals:
//   len        term count, sampled with the first term of a product
//   in_valid   term valid          in_ready  term accepted when both high
//   in_a/in_b  signed term operands in_sub   subtract this term's product
//   out_valid  result valid        out_ready result consumed when both high
//   out_p      signed dot product
interface dsp48_dot_seq_if #(
  parameter int NBA = 24,
  parameter int NBB = 18,
  parameter int NBP = 48,
  parameter int LW  = 10
);
  logic [LW-1:0]         len;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [NBA-1:0] in_a;
  logic signed [NBB-1:0] in_b;
  logic                  in_sub;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [NBP-1:0] out_p;

  modport master (
    output len, in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  len, in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/dsp48_dot_seq.sv
// Dot-product sequencer driving a dsp48_wrap (AREG=1, BREG=1, no D port)
// as a multiply-accumulate engine.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   s             term input / result output streams (slave modport)
//   dsp_a, dsp_b  registered multiplier operands to the DSP
//   dsp_mode      registered mode word: [3:2] 0=P=M, 2=P=M+P; [1:0] 3=subtract
//   dsp_p         accumulator output from the DSP
// A term accepted at edge k reaches DSP P at edge k+3; its mode word goes
// through one extra pipe stage so the DSP mode registers line up with M.
module dsp48_dot_seq #(
  parameter int NBA = 24,
  parameter int NBB = 18,
  parameter int NBP = 48,
  parameter int LW  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  dsp48_dot_seq_if.slave        s,
  output logic signed [NBA-1:0] dsp_a,
  output logic signed [NBB-1:0] dsp_b,
  output logic [4:0]            dsp_mode,
  input  logic signed [NBP-1:0] dsp_p
);

  // Bubble: zero operands accumulate nothing onto P.
  localparam logic [4:0] MODE_BUBBLE = 5'b01000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [LW-1:0]         cnt_r, cnt_s;
  logic [1:0]            drain_r, drain_s;
  logic                  in_ready_r, in_ready_s;
  logic                  out_valid_r, out_valid_s;
  logic signed [NBP-1:0] out_p_r, out_p_s;
  logic signed [NBA-1:0] dsp_a_r;
  logic signed [NBB-1:0] dsp_b_r;
  logic [4:0]            mode_pipe_r, dsp_mode_r;
  logic [4:0]            term_mode_s;
  logic                  accept_s;

  assign accept_s    = s.in_valid && in_ready_r;
  assign s.in_ready  = in_ready_r;
  assign s.out_valid = out_valid_r;
  assign s.out_p     = out_p_r;
  assign dsp_a       = dsp_a_r;
  assign dsp_b       = dsp_b_r;
  assign dsp_mode    = dsp_mode_r;

  // Mode word for the current cycle: first term loads P=M, later terms add/sub.
  always_comb begin
    term_mode_s = MODE_BUBBLE;
    if (accept_s) begin
      term_mode_s = {1'b0,
                     (state_r == IDLE) ? 2'b00 : 2'b10,
                     s.in_sub ? 2'b11 : 2'b00};
    end else begin
      term_mode_s = MODE_BUBBLE;
    end
  end

  // Next-state and control-register values.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    drain_s     = drain_r;
    out_valid_s = out_valid_r;
    out_p_s     = out_p_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          // len of 0 or 1 both mean a single-term product.
          if (s.len <= LW'(1)) begin
            cnt_s   = '0;
            drain_s = 2'd3;
            state_s = DRAIN;
          end else begin
            cnt_s   = s.len - LW'(1);
            state_s = ACC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          if (cnt_r == LW'(1)) begin
            cnt_s   = '0;
            drain_s = 2'd3;
            state_s = DRAIN;
          end else begin
            cnt_s = cnt_r - LW'(1);
          end
        end else begin
          state_s = ACC;
        end
      end
      DRAIN: begin
        // Counter reaches zero three edges after the last accept; the
        // final P is valid on dsp_p at the fourth edge.
        if (drain_r == 2'd0) begin
          out_p_s     = dsp_p;
          out_valid_s = 1'b1;
          state_s     = HOLD;
        end else begin
          drain_s = drain_r - 2'd1;
        end
      end
      HOLD: begin
        if (s.out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    in_ready_s = (state_s == IDLE) || (state_s == ACC);
  end

  // State and control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      drain_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_p_r     <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      drain_r     <= drain_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_p_r     <= out_p_s;
    end
  end

  // DSP operand and mode pipeline; operands zero in bubble cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dsp_a_r     <= '0;
      dsp_b_r     <= '0;
      mode_pipe_r <= MODE_BUBBLE;
      dsp_mode_r  <= MODE_BUBBLE;
    end else begin
      dsp_a_r     <= accept_s ? s.in_a : '0;
      dsp_b_r     <= accept_s ? s.in_b : '0;
      mode_pipe_r <= term_mode_s;
      dsp_mode_r  <= mode_pipe_r;
    end
  end

endmodule

// File: tb/tb_dsp48_dot_seq.sv
// Bench for dsp48_dot_seq with a behavioural dsp48_wrap stand-in
// (A/B reg, M reg, P reg, mode reg aligned with M).
module tb_dsp48_dot_seq;
  localparam int NBA = 24;
  localparam int NBB = 18;
  localparam int NBP = 48;
  localparam int LW  = 10;

  typedef struct {
    logic signed [NBP-1:0] p;
    int                    edge_n;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic signed [NBA-1:0] dsp_a;
  logic signed [NBB-1:0] dsp_b;
  logic [4:0]            dsp_mode;
  logic signed [NBP-1:0] dsp_p;

  dsp48_dot_seq_if #(.NBA(NBA), .NBB(NBB), .NBP(NBP), .LW(LW)) bus ();

  dsp48_dot_seq #(.NBA(NBA), .NBB(NBB), .NBP(NBP), .LW(LW)) dut (
    .clock    (clock),
    .reset    (reset),
    .s        (bus),
    .dsp_a    (dsp_a),
    .dsp_b    (dsp_b),
    .dsp_mode (dsp_mode),
    .dsp_p    (dsp_p)
  );

  always #5 clock = ~clock;

  // DSP model
  logic signed [NBA-1:0] areg  = '0;
  logic signed [NBB-1:0] breg  = '0;
  logic [4:0]            opreg = 5'b01000;
  logic signed [NBP-1:0] mreg  = '0;
  logic signed [NBP-1:0] preg  = '0;
  logic signed [NBP-1:0] prod_s, z_s, pnext_s;
  assign prod_s  = NBP'(areg) * NBP'(breg);
  assign z_s     = (opreg[3:2] == 2'b10) ? preg : '0;
  assign pnext_s = (opreg[1:0] == 2'b11) ? (z_s - mreg) : (z_s + mreg);
  assign dsp_p   = preg;

  always @(posedge clock) begin
    areg  <= dsp_a;
    breg  <= dsp_b;
    opreg <= dsp_mode;
    mreg  <= prod_s;
    preg  <= pnext_s;
  end

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int     n_cmp = 0;
  int     n_err = 0;
  exp_t   sb[$];
  int     acc_edge = 0;
  int     drain_set = 0;
  int     drain_clr = 0;
  longint ta[4];
  longint tbv[4];
  logic   ts[4];

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: latency at out_valid rise, value at handshake, hold stability.
  logic                  prev_valid = 1'b0;
  logic                  prev_ready = 1'b0;
  logic signed [NBP-1:0] prev_p = '0;
  exp_t                  e;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.out_valid && !prev_valid) begin
        check("result_pending", longint'(sb.size() != 0), 1);
        if (sb.size() != 0) check("latency_edge", edge_cnt, sb[0].edge_n);
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_p", bus.out_p, prev_p);
      end
      if (bus.out_valid || (drain_set != drain_clr)) check("busy_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (drain_set != drain_clr) drain_clr <= drain_clr + 1;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_p", bus.out_p, e.p);
        end
      end
      prev_valid <= bus.out_valid;
      prev_ready <= bus.out_ready;
      prev_p     <= bus.out_p;
    end else begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end
  end

  task automatic send_term(input longint a, input longint b, input logic sub, input int lenv);
    logic ok;
    bus.in_a     = a[NBA-1:0];
    bus.in_b     = b[NBB-1:0];
    bus.in_sub   = sub;
    bus.len      = lenv[LW-1:0];
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", ok, 1);
    if (ok) begin
      @(posedge clock);
      #1;
      acc_edge = edge_cnt;
    end else begin
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic product(input int n, input int lenv, input int gap, input longint expv);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      send_term(ta[i], tbv[i], ts[i], lenv);
      if (i == n - 1) begin
        x.p      = expv[NBP-1:0];
        x.edge_n = acc_edge + 4;
        sb.push_back(x);
        drain_set = drain_set + 1;
      end else begin
        repeat (gap) begin
          @(posedge clock);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_p", bus.out_p, 0);
    check("rst_dsp_a", dsp_a, 0);
    check("rst_dsp_b", dsp_b, 0);
    check("rst_dsp_mode", dsp_mode, 8);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: continuous 4-term product
    ta = '{1, 2, 3, 4}; tbv = '{5, 6, 7, 8}; ts = '{1'b0, 1'b0, 1'b0, 1'b0};
    product(4, 4, 0, 70);
    // 2: gaps of 3, subtract the third term
    ts = '{1'b0, 1'b0, 1'b1, 1'b0};
    product(4, 4, 3, 28);
    // 3: single-term products, len 0 and 1, first-term subtract
    ta[0] = -5; tbv[0] = 7; ts[0] = 1'b0;
    product(1, 0, 0, -35);
    product(1, 1, 0, -35);
    ts[0] = 1'b1;
    product(1, 1, 0, 35);
    // 4: backpressure on result, then a fresh product
    wait_drain();
    bus.out_ready = 1'b0;
    ta = '{1, 2, 3, 4}; tbv = '{5, 6, 7, 8}; ts = '{1'b0, 1'b0, 1'b0, 1'b0};
    product(4, 4, 0, 70);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clock);
    check("hold_seen", bus.out_valid, 1);
    repeat (20) @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    ta[0] = 2; ta[1] = 3; tbv[0] = 4; tbv[1] = 5;
    product(2, 2, 0, 23);
    // 5: wraparound-free extreme products
    ta[0] = -8388608; ta[1] = -8388608; tbv[0] = -131072; tbv[1] = -131072;
    product(2, 2, 0, 64'sd2199023255552);
    // 6: reset in the middle of an accumulation
    wait_drain();
    send_term(9, 9, 1'b0, 4);
    send_term(9, 9, 1'b0, 4);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    ta[0] = 1; ta[1] = 1; tbv[0] = 1; tbv[1] = 1;
    product(2, 2, 0, 2);
    wait_drain();
    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
